// File: rtl/johnson_phase_sequencer_if.sv
// Control/status bundle between a control master and the Johnson phase sequencer.
// The master drives run control; the sequencer returns the counter, phase strobes and progress flags.
interface johnson_phase_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();
  logic               start;
  logic [CNT_W-1:0]   cycles;
  logic               stop;
  logic               hold;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] phase;
  logic               busy;
  logic               rot_done;
  logic               done;
  logic               err;

  modport master (
    output start, cycles, stop, hold,
    input  q, phase, busy, rot_done, done, err
  );

  modport slave (
    input  start, cycles, stop, hold,
    output q, phase, busy, rot_done, done, err
  );
endinterface

// File: rtl/johnson_phase_sequencer.sv
// Runs a WIDTH-stage Johnson counter for a programmed number of rotations (or until stopped),
// decodes it to one-hot phase strobes and recovers from illegal register states.
module johnson_phase_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    clear,
  johnson_phase_sequencer_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  // k-th code of the twisted-ring sequence: ones fill from the LSB, then drain from the LSB.
  function automatic logic [WIDTH-1:0] johnson_code(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) begin
      johnson_code = ~(ones << k);
    end else begin
      johnson_code = ones << (k - WIDTH);
    end
  endfunction

  // One-hot position of v in the sequence; all-zero flags a non-Johnson state.
  function automatic logic [2*WIDTH-1:0] phase_decode(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] oh;
    oh = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if (v == johnson_code(k)) begin
        oh[k] = 1'b1;
      end else begin
        oh[k] = 1'b0;
      end
    end
    return oh;
  endfunction

  logic [0:0]         state_r, state_nxt_s;
  logic [WIDTH-1:0]   q_r, q_nxt_s;
  logic [2*WIDTH-1:0] phase_r, phase_nxt_s;
  logic [CNT_W-1:0]   cyc_left_r, cyc_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               rot_done_r, rot_nxt_s;
  logic               done_r, done_nxt_s;
  logic               err_r, err_nxt_s;
  logic               stop_pending_r, stop_nxt_s;
  logic               legal_s;
  logic               end_run_s;

  assign legal_s = |phase_decode(q_r);

  // Next-state computation for the run controller and counter.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    cyc_nxt_s   = cyc_left_r;
    stop_nxt_s  = stop_pending_r;
    err_nxt_s   = err_r;
    rot_nxt_s   = 1'b0;
    done_nxt_s  = 1'b0;
    end_run_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        q_nxt_s = '0;
        if (bus.start) begin
          cyc_nxt_s   = bus.cycles;
          stop_nxt_s  = 1'b0;
          err_nxt_s   = 1'b0;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          stop_nxt_s = 1'b1;
        end else begin
          stop_nxt_s = stop_pending_r;
        end
        // Illegal codes abort silently (no done), even while held.
        if (!legal_s) begin
          err_nxt_s   = 1'b1;
          q_nxt_s     = '0;
          state_nxt_s = ST_IDLE;
        end else if (bus.hold) begin
          q_nxt_s = q_r;
        end else begin
          q_nxt_s = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
          if (q_r == LAST_CODE) begin
            rot_nxt_s = 1'b1;
            end_run_s = stop_pending_r | bus.stop | (cyc_left_r == CNT_W'(1));
            if (end_run_s) begin
              state_nxt_s = ST_IDLE;
              done_nxt_s  = 1'b1;
            end else if (cyc_left_r != '0) begin
              cyc_nxt_s = cyc_left_r - CNT_W'(1);
            end else begin
              cyc_nxt_s = cyc_left_r;
            end
          end else begin
            cyc_nxt_s = cyc_left_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        q_nxt_s     = '0;
      end
    endcase
    busy_nxt_s  = (state_nxt_s == ST_RUN);
    phase_nxt_s = busy_nxt_s ? phase_decode(q_nxt_s) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r        <= ST_IDLE;
      q_r            <= '0;
      phase_r        <= '0;
      cyc_left_r     <= '0;
      busy_r         <= 1'b0;
      rot_done_r     <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      stop_pending_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      q_r            <= q_nxt_s;
      phase_r        <= phase_nxt_s;
      cyc_left_r     <= cyc_nxt_s;
      busy_r         <= busy_nxt_s;
      rot_done_r     <= rot_nxt_s;
      done_r         <= done_nxt_s;
      err_r          <= err_nxt_s;
      stop_pending_r <= stop_nxt_s;
    end
  end

  assign bus.q        = q_r;
  assign bus.phase    = phase_r;
  assign bus.busy     = busy_r;
  assign bus.rot_done = rot_done_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: doc/johnson_phase_sequencer.md
# johnson_phase_sequencer

Controller that owns and sequences a WIDTH-stage Johnson (twisted-ring) counter. It runs the counter for a programmed number of full rotations, or continuously until stopped, with hold (pause) support. It decodes the current counter state to a one-hot phase bus and reports progress through busy / rot_done / done. It also detects illegal (non-Johnson) register states and recovers from them. It sits between a control master and downstream logic that consumes multi-phase timing strobes.

## Interface
- WIDTH, 4: Johnson stages; legal range 2..16; 2*WIDTH states per rotation.
- CNT_W, 8: width of the rotation-count input.

- clk  in  1  clock; all flops update on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- cycles  in  CNT_W  rotations to run; 0 = continuous until stop.
- stop  in  1  graceful-stop request; run ends at the next rotation boundary.
- hold  in  1  pause; freezes the counter and all progress state while high.
- q  out  WIDTH  Johnson counter register.
- phase  out  2*WIDTH  one-hot decode of q; all-zero when not busy.
- busy  out  1  high while a run is in progress.
- rot_done  out  1  one-cycle pulse on each completed rotation.
- done  out  1  one-cycle pulse on normal run completion.
- err  out  1  sticky illegal-state flag.

## Operation
- States: IDLE and RUN.
- Reset (clear=0, asynchronous): q=0, phase=0, busy=0, rot_done=0, done=0, err=0, stop_pending=0, cyc_left=0, state=IDLE.
- IDLE: q held at 0, phase=0.
  - start=1 at an edge: latch cycles into cyc_left, clear stop_pending, clear err, go to RUN.
  - stop and hold are ignored.
- RUN, hold=0: each edge advances q to {q[WIDTH-2:0], ~q[WIDTH-1]}. Sequence for WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- phase[k]=1 when q is the k-th state of the sequence (k = 0..2*WIDTH-1), gated by busy.
- Rotation boundary = an advance from the last state (1 followed by WIDTH-1 zeros) back to 0. At each boundary:
  - rot_done pulses.
  - If continuous mode: end the run if stop_pending or stop=1 on that edge, otherwise continue.
  - Otherwise: end the run if cyc_left==1 or stop_pending or stop=1; otherwise decrement cyc_left.
  - Ending a run: go to IDLE, busy=0, pulse done once.
- stop=1 on any RUN edge sets stop_pending, including while hold=1.
- RUN, hold=1: q, cyc_left and state are frozen. No rot_done or done. phase keeps showing the current state.
- Illegal-state check, every RUN edge:
  - A legal state has at most one 0→1 transition scanning from MSB to LSB and matches one of the 2*WIDTH codes.
  - On an illegal state: err=1, q=0, go to IDLE, busy=0, no done pulse.
  - err stays set until the next accepted start or reset.
- start while busy: ignored. cycles is sampled only when start is accepted.

## Timing
- Start latency: start accepted at edge T → busy=1, q=0, phase[0]=1 visible after T.
- First advance happens at edge T+1.
- Run length with no holds: N rotations take N*2*WIDTH cycles. Boundary edges fall at T+k*2*WIDTH.
- The final boundary edge T+N*2*WIDTH drives together: done=1, rot_done=1, busy=0, q=0.
- Each hold cycle extends the run by exactly one cycle.
- A new start is accepted no earlier than the edge after done, i.e. one idle cycle minimum.
- Reset mid-run: outputs go to reset values immediately and asynchronously; no done pulse.
- Simultaneous events:
  - stop on the final boundary edge: one done pulse only.
  - stop and hold high together: stop is latched and the counter stays frozen.

## Test plan
- Reset: assert clear mid-stream → q=0000, phase=0, busy=done=rot_done=err=0, all immediately.
- Two rotations: WIDTH=4, cycles=2, start at T → q follows the 8-state sequence twice; rot_done at T+8 and T+16; done and busy fall at T+16 only.
- Hold: cycles=1, hold high for 3 cycles while q=0111 → q stays frozen; done moves from T+8 to T+11; phase[3] held throughout.
- Continuous + stop: cycles=0, pulse stop while q=0011 (3rd rotation) → run ends at the following boundary; exactly one done; rot_done count = 3.
- Ignored inputs: start during RUN → no restart and cyc_left unchanged; stop in IDLE → no effect; stop coinciding with the final boundary of cycles=1 → exactly one done pulse.
- Illegal state: force q=0101 during RUN → next edge: err=1, q=0000, busy=0, no done; a following start clears err and the run proceeds normally.
